row_receiver: RTL and testbench

Downstream consumer of the row serializer that feeds the CNN accelerator. It takes an image as a stream of narrow bus beats under a valid/ready handshake and reassembles each group of ROW_W/BUS_W beats into one full row. Each completed row is written to the accelerator's row buffer through a single-cycle write port. When all NUM_ROWS rows of an image are stored, it signals completion.

---
 rtl/row_receiver.sv | 179 +++++++++++++++++
 tb/tb_row_receiver.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/row_receiver.sv
`default_nettype none
//============================================================================
//  Module   : row_receiver
//  Purpose  : Reassembles a stream of BUS_W-bit beats (valid/ready handshake)
//             into ROW_W-bit image rows. Each completed row goes to the
//             accelerator row buffer through a single-cycle write port. A
//             one-cycle done pulse follows the write of the last row of an
//             image.
//
//  Ports    : clk          system clock, rising edge
//             rst          synchronous, active-low reset
//             start        begin a new image (honoured only when idle)
//             in_valid     upstream beat valid
//             in_data      beat payload, first beat of a row is its MSBs
//             in_last      upstream marker for the final beat of a row
//             in_ready     receiver accepts a beat this cycle
//             wr_en        row-buffer write strobe, one cycle per row
//             wr_addr      row index being written (held between writes)
//             wr_data      assembled row (held between writes)
//             done         one-cycle pulse after the final row is written
//             busy         receiver is not idle
//             framing_err  sticky flag, in_last seen in the wrong place
//
//  Revision : 1.0  initial release
//============================================================================
module row_receiver #(
    parameter int ROW_W    = 480,
    parameter int BUS_W    = 16,
    parameter int NUM_ROWS = 30,
    parameter int AW       = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [BUS_W-1:0]  in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              wr_en,
    output logic [AW-1:0]     wr_addr,
    output logic [ROW_W-1:0]  wr_data,
    output logic              done,
    output logic              busy,
    output logic              framing_err
);

    // ------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------
    localparam int c_BEATS = ROW_W / BUS_W;
    localparam int c_CW    = (c_BEATS > 1) ? $clog2(c_BEATS + 1) : 1;

    localparam logic [c_CW-1:0] c_LAST_BEAT = c_CW'(c_BEATS - 1);
    localparam logic [AW-1:0]   c_LAST_ROW  = AW'(NUM_ROWS - 1);

    // State encoding
    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RECV  = 2'd1;
    localparam logic [1:0] c_WRITE = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    logic [1:0]        r_state;
    logic [c_CW-1:0]   r_beat_cnt;
    logic [AW-1:0]     r_row_cnt;
    logic [ROW_W-1:0]  r_shift;
    logic [ROW_W-1:0]  r_wr_data;
    logic [AW-1:0]     r_wr_addr;
    logic              r_framing_err;

    logic              w_xfer;
    logic              w_last_beat;
    logic              w_early_last;
    logic [ROW_W-1:0]  w_shift_next;

    // A beat moves only while receiving; in_ready is a pure state decode.
    assign w_xfer       = in_valid && (r_state == c_RECV);
    assign w_last_beat  = (r_beat_cnt == c_LAST_BEAT);
    // in_last before the final beat position means the upstream lost sync.
    assign w_early_last = in_last && !w_last_beat;

    // MSB-first assembly: older beats move up, the new beat enters at the
    // bottom, so after BEATS transfers the first beat sits at the top.
    generate
        if (c_BEATS > 1) begin : g_shift_multi
            assign w_shift_next = {r_shift[ROW_W-BUS_W-1:0], in_data};
        end else begin : g_shift_single
            assign w_shift_next = in_data;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Control FSM and datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= c_IDLE;
            r_beat_cnt    <= '0;
            r_row_cnt     <= '0;
            r_shift       <= '0;
            r_wr_data     <= '0;
            r_wr_addr     <= '0;
            r_framing_err <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_row_cnt     <= '0;
                        r_beat_cnt    <= '0;
                        r_shift       <= '0;
                        r_framing_err <= 1'b0;
                        r_state       <= c_RECV;
                    end
                end

                c_RECV: begin
                    if (w_xfer) begin
                        if (w_early_last) begin
                            // Drop the partial row and resynchronise on the
                            // next beat; the row index is reused.
                            r_framing_err <= 1'b1;
                            r_beat_cnt    <= '0;
                            r_shift       <= '0;
                        end else if (w_last_beat) begin
                            // Missing in_last is flagged but the row is
                            // still complete by count, so it is written.
                            if (!in_last) begin
                                r_framing_err <= 1'b1;
                            end
                            r_wr_data  <= w_shift_next;
                            r_wr_addr  <= r_row_cnt;
                            r_shift    <= '0;
                            r_beat_cnt <= r_beat_cnt + 1'b1;
                            r_state    <= c_WRITE;
                        end else begin
                            r_shift    <= w_shift_next;
                            r_beat_cnt <= r_beat_cnt + 1'b1;
                        end
                    end
                end

                c_WRITE: begin
                    r_beat_cnt <= '0;
                    if (r_row_cnt == c_LAST_ROW) begin
                        r_state <= c_DONE;
                    end else begin
                        r_row_cnt <= r_row_cnt + 1'b1;
                        r_state   <= c_RECV;
                    end
                end

                c_DONE: begin
                    r_state <= c_IDLE;
                end

                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // wr_data/wr_addr are loaded on the final-beat edge so they are valid
    // throughout the WRITE cycle and hold afterwards.
    assign in_ready    = (r_state == c_RECV);
    assign wr_en       = (r_state == c_WRITE);
    assign done        = (r_state == c_DONE);
    assign busy        = (r_state != c_IDLE);
    assign wr_addr     = r_wr_addr;
    assign wr_data     = r_wr_data;
    assign framing_err = r_framing_err;

endmodule
`default_nettype wire

// File: tb/tb_row_receiver.sv
`default_nettype none
//============================================================================
//  Module   : tb_row_receiver
//  Purpose  : Self-checking bench for row_receiver. A table of image
//             scenarios is streamed through the receiver; a negedge monitor
//             checks every row write (address, data, spacing) and the done
//             pulse. A hand-written sequence covers reset mid-image.
//  Revision : 1.0  initial release
//============================================================================
module tb_row_receiver;

    localparam int ROW_W    = 480;
    localparam int BUS_W    = 16;
    localparam int NUM_ROWS = 30;
    localparam int AW       = 5;
    localparam int BEATS    = ROW_W / BUS_W;

    logic              clk;
    logic              rst;
    logic              start;
    logic              in_valid;
    logic [BUS_W-1:0]  in_data;
    logic              in_last;
    logic              in_ready;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [ROW_W-1:0]  wr_data;
    logic              done;
    logic              busy;
    logic              framing_err;

    row_receiver #(
        .ROW_W    (ROW_W),
        .BUS_W    (BUS_W),
        .NUM_ROWS (NUM_ROWS),
        .AW       (AW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_last     (in_last),
        .in_ready    (in_ready),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .done        (done),
        .busy        (busy),
        .framing_err (framing_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected row r: beat k = {r[7:0], k[7:0]}, first beat at the MSBs.
    function automatic logic [ROW_W-1:0] exp_row(input int r);
        logic [ROW_W-1:0] row;
        logic [7:0]       rb;
        logic [7:0]       kb;
        row = '0;
        rb  = r[7:0];
        for (int k = 0; k < BEATS; k++) begin
            kb = k[7:0];
            row[ROW_W-1-BUS_W*k -: BUS_W] = {rb, kb};
        end
        return row;
    endfunction

    // ------------------------------------------------------------------
    // Write/done monitor (samples on negedge)
    // ------------------------------------------------------------------
    int epoch     = 0;
    int seen_ep   = 0;
    int cyc       = 0;
    int mon_addr  = 0;
    int mon_wr    = 0;
    int mon_done  = 0;
    int last_wr   = -100;
    bit prev_done = 1'b0;
    bit gap_chk   = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (epoch != seen_ep) begin
            seen_ep  = epoch;
            mon_addr = 0;
            mon_wr   = 0;
            mon_done = 0;
            last_wr  = -100;
        end
        if (prev_done) begin
            check("busy_after_done", 512'(busy), 512'(0));
            check("done_width", 512'(done), 512'(0));
        end
        prev_done = done;
        if (wr_en) begin
            check("wr_addr", 512'(wr_addr), 512'(mon_addr));
            check("wr_data", 512'(wr_data), 512'(exp_row(mon_addr)));
            if (gap_chk && mon_wr > 0)
                check("row_period", 512'(cyc - last_wr), 512'(BEATS + 1));
            last_wr = cyc;
            mon_wr++;
            mon_addr++;
        end
        if (done) begin
            check("done_latency", 512'(cyc - last_wr), 512'(1));
            mon_done++;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (drive at posedge+1)
    // ------------------------------------------------------------------
    task automatic abort(input string why);
        n_err++;
        $display("FAIL %s: bound expired", why);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "bench aborted");
    endtask

    task automatic send_beat(input logic [BUS_W-1:0] d, input logic l,
                             input int pct, input logic st);
        bit xfer;
        int tries;
        in_data = d;
        in_last = l;
        start   = st;
        xfer    = 1'b0;
        tries   = 0;
        while (!xfer) begin
            in_valid = ($urandom_range(99) < pct);
            xfer     = in_valid && in_ready;
            @(posedge clk);
            #1;
            tries++;
            if (tries > 1000) abort("beat_timeout");
        end
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    typedef struct {
        int pct;         // in_valid duty in percent
        int bad_early;   // row preceded by an aborted attempt, -1 none
        int bad_late;    // row whose final beat lacks in_last, -1 none
        int start_row;   // row during which start is pulsed, -1 none
        bit exp_err;     // expected framing_err at image end
        bit gap;         // check 31-cycle row period
    } scen_t;

    task automatic run_image(input scen_t s);
        logic [7:0] rb;
        logic [7:0] kb;
        int         w;
        epoch++;
        gap_chk = s.gap;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_start", 512'(busy), 512'(1));
        check("err_clear_on_start", 512'(framing_err), 512'(0));
        check("ready_in_recv", 512'(in_ready), 512'(1));
        for (int r = 0; r < NUM_ROWS; r++) begin
            rb = r[7:0];
            if (r == s.bad_early) begin
                for (int k = 0; k <= 10; k++) begin
                    kb = k[7:0];
                    send_beat({rb, kb}, (k == 10), s.pct, 1'b0);
                end
                check("early_last_err", 512'(framing_err), 512'(1));
            end
            for (int k = 0; k < BEATS; k++) begin
                kb = k[7:0];
                send_beat({rb, kb}, (r == s.bad_late) ? 1'b0 : (k == BEATS - 1),
                          s.pct, (r == s.start_row && k == 5));
            end
        end
        w = 0;
        while (!done) begin
            @(posedge clk);
            #1;
            w++;
            if (w > 10) abort("done_wait");
        end
        @(posedge clk);
        #1;
        check("write_count", 512'(mon_wr), 512'(NUM_ROWS));
        check("done_count", 512'(mon_done), 512'(1));
        check("framing_err_end", 512'(framing_err), 512'(s.exp_err));
        check("idle_after_done", 512'(busy), 512'(0));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"}, 512'(in_ready), 512'(0));
        check({tag, "_wr_en"}, 512'(wr_en), 512'(0));
        check({tag, "_wr_addr"}, 512'(wr_addr), 512'(0));
        check({tag, "_wr_data"}, 512'(wr_data), 512'(0));
        check({tag, "_done"}, 512'(done), 512'(0));
        check({tag, "_busy"}, 512'(busy), 512'(0));
        check({tag, "_framing_err"}, 512'(framing_err), 512'(0));
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    scen_t tbl[5];

    initial begin
        logic [7:0] rb;
        logic [7:0] kb;

        tbl[0] = '{pct: 100, bad_early: -1, bad_late: -1, start_row: -1, exp_err: 1'b0, gap: 1'b1};
        tbl[1] = '{pct: 50,  bad_early: -1, bad_late: -1, start_row: -1, exp_err: 1'b0, gap: 1'b0};
        tbl[2] = '{pct: 100, bad_early: 3,  bad_late: -1, start_row: -1, exp_err: 1'b1, gap: 1'b0};
        tbl[3] = '{pct: 100, bad_early: -1, bad_late: 5,  start_row: -1, exp_err: 1'b1, gap: 1'b1};
        tbl[4] = '{pct: 100, bad_early: -1, bad_late: -1, start_row: 2,  exp_err: 1'b0, gap: 1'b1};

        rst      = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 5; i++) begin
            run_image(tbl[i]);
            repeat (2) @(posedge clk);
            #1;
        end

        // Reset after row 7 beat 12 of an image with a framing error on row 1.
        epoch++;
        gap_chk = 1'b0;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int r = 0; r < 8; r++) begin
            rb = r[7:0];
            for (int k = 0; k < ((r == 7) ? 13 : BEATS); k++) begin
                kb = k[7:0];
                send_beat({rb, kb}, (r == 1) ? 1'b0 : (k == BEATS - 1), 100, 1'b0);
            end
        end
        check("pre_reset_err", 512'(framing_err), 512'(1));
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        check_all_zero("mid_reset");
        repeat (3) @(posedge clk);
        #1;
        check("no_write_after_reset", 512'(wr_en | done), 512'(0));
        run_image(tbl[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
